// File: rtl/pc_ctrl_pkg.sv
// pc_ctrl_pkg: shared state, mode and branch-condition definitions for the PC controller
package pc_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_HALT  = 2'b00,
    ST_RUN   = 2'b01,
    ST_STEP  = 2'b10,
    ST_FAULT = 2'b11
  } state_t;

  localparam logic [1:0] MODE_RUN  = 2'b00;
  localparam logic [1:0] MODE_STEP = 2'b01;

  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;
  localparam logic [2:0] F3_BLT  = 3'b100;
  localparam logic [2:0] F3_BGE  = 3'b101;
  localparam logic [2:0] F3_BLTU = 3'b110;
  localparam logic [2:0] F3_BGEU = 3'b111;

  // Codes 010/011 have no branch meaning and never take.
  function automatic logic branch_cond(input logic [2:0] f3, input logic zero,
                                       input logic lt, input logic ltu);
    case (f3)
      F3_BEQ:  return zero;
      F3_BNE:  return !zero;
      F3_BLT:  return lt;
      F3_BGE:  return !lt;
      F3_BLTU: return ltu;
      F3_BGEU: return !ltu;
      default: return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/tick_gen.sv
// tick_gen: RUN-mode tick divider plus synchronised step-button edge detector producing the advance pulse
module tick_gen
  import pc_ctrl_pkg::*;
#(
  parameter int TICK_DIV = 25_000_000
) (
  input  logic   i_clk,
  input  logic   i_rst_n,
  input  state_t i_state,
  input  logic   i_step_n,
  output logic   o_advance
);

  localparam int CW = $clog2(TICK_DIV);

  logic [CW-1:0] r_cnt;
  logic          r_sync1;
  logic          r_sync2;
  logic          r_prev;
  logic          w_run;
  logic          w_wrap;
  logic          w_fall;

  assign w_run  = (i_state == ST_RUN);
  assign w_wrap = (r_cnt == CW'(TICK_DIV - 1));
  assign w_fall = r_prev && !r_sync2;

  // Counter runs only while in RUN; any other state restarts it from zero.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) r_cnt <= '0;
    else          r_cnt <= (w_run && !w_wrap) ? r_cnt + CW'(1) : '0;
  end

  // Two-flop synchroniser and previous-value flop; idle level of the button is high.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_sync1 <= 1'b1;
      r_sync2 <= 1'b1;
      r_prev  <= 1'b1;
    end else begin
      r_sync1 <= i_step_n;
      r_sync2 <= r_sync1;
      r_prev  <= r_sync2;
    end
  end

  // Edges seen outside STEP are simply not used, so nothing is queued.
  assign o_advance = (w_run && w_wrap) || ((i_state == ST_STEP) && w_fall);

endmodule

// File: rtl/program_counter_ctrl.sv
// program_counter_ctrl: PC register with RUN/STEP/HALT pacing, branch/jump/jalr target selection and misalignment fault
module program_counter_ctrl
  import pc_ctrl_pkg::*;
#(
  parameter int          ADDR_W   = 8,
  parameter int unsigned RESET_PC = 0,
  parameter int          TICK_DIV = 25_000_000
) (
  input  logic              clock_reg,
  input  logic              reset,
  input  logic [1:0]        mode,
  input  logic              step_n,
  input  logic              branch,
  input  logic              jump,
  input  logic              jalr,
  input  logic [2:0]        funct3,
  input  logic              zero,
  input  logic              lt,
  input  logic              ltu,
  input  logic [ADDR_W-1:0] imm,
  input  logic [ADDR_W-1:0] rs1,
  output logic [ADDR_W-1:0] PC,
  output logic [ADDR_W-1:0] PCp4,
  output logic              advance,
  output logic              taken,
  output logic              fault
);

  state_t              r_state;
  state_t              w_state_nx;
  logic [ADDR_W-1:0]   r_pc;
  logic                r_fault;
  logic [ADDR_W-1:0]   w_rel;
  logic [ADDR_W-1:0]   w_jalr;
  logic [ADDR_W-1:0]   w_target;
  logic                w_br_take;
  logic                w_misalign;
  logic                w_fault_hit;

  tick_gen #(
    .TICK_DIV (TICK_DIV)
  ) u_tick_gen (
    .i_clk     (clock_reg),
    .i_rst_n   (reset),
    .i_state   (r_state),
    .i_step_n  (step_n),
    .o_advance (advance)
  );

  assign PC          = r_pc;
  assign fault       = r_fault;
  assign PCp4        = r_pc + ADDR_W'(4);
  assign w_rel       = r_pc + imm;
  assign w_jalr      = (rs1 + imm) & ~ADDR_W'(1);
  assign w_br_take   = branch && branch_cond(funct3, zero, lt, ltu);
  assign taken       = jalr || jump || w_br_take;
  assign w_target    = jalr ? w_jalr : (jump || w_br_take) ? w_rel : PCp4;
  assign w_misalign  = taken && (w_target[1:0] != 2'b00);
  assign w_fault_hit = advance && w_misalign;

  // State register.
  always_ff @(posedge clock_reg or negedge reset) begin
    if (!reset) r_state <= ST_HALT;
    else        r_state <= w_state_nx;
  end

  // FAULT is absorbing; otherwise the mode input picks the next state.
  always_comb begin
    w_state_nx = ST_HALT;
    w_state_nx = (r_state == ST_FAULT || w_fault_hit) ? ST_FAULT :
                 (mode == MODE_RUN)  ? ST_RUN  :
                 (mode == MODE_STEP) ? ST_STEP : ST_HALT;
  end

  // PC loads the target on advance unless it is a misaligned flow change, which latches the fault instead.
  always_ff @(posedge clock_reg or negedge reset) begin
    if (!reset) begin
      r_pc    <= ADDR_W'(RESET_PC);
      r_fault <= 1'b0;
    end else begin
      if (advance && !w_misalign) r_pc <= w_target;
      if (w_fault_hit)            r_fault <= 1'b1;
    end
  end

endmodule

// File: tb/tb_program_counter_ctrl.sv
// tb_program_counter_ctrl: directed-vector bench for the PC controller
module tb_program_counter_ctrl;

  logic       clock_reg = 1'b0;
  logic       reset     = 1'b0;
  logic [1:0] mode      = 2'b10;
  logic       step_n    = 1'b1;
  logic       branch    = 1'b0;
  logic       jump      = 1'b0;
  logic       jalr      = 1'b0;
  logic [2:0] funct3    = 3'b000;
  logic       zero      = 1'b0;
  logic       lt        = 1'b0;
  logic       ltu       = 1'b0;
  logic [7:0] imm       = 8'h00;
  logic [7:0] rs1       = 8'h00;
  logic [7:0] PC;
  logic [7:0] PCp4;
  logic       advance;
  logic       taken;
  logic       fault;

  int n_tests = 0;
  int n_fail  = 0;

  program_counter_ctrl #(
    .ADDR_W   (8),
    .RESET_PC (0),
    .TICK_DIV (4)
  ) dut (
    .clock_reg (clock_reg),
    .reset     (reset),
    .mode      (mode),
    .step_n    (step_n),
    .branch    (branch),
    .jump      (jump),
    .jalr      (jalr),
    .funct3    (funct3),
    .zero      (zero),
    .lt        (lt),
    .ltu       (ltu),
    .imm       (imm),
    .rs1       (rs1),
    .PC        (PC),
    .PCp4      (PCp4),
    .advance   (advance),
    .taken     (taken),
    .fault     (fault)
  );

  always #5 clock_reg = ~clock_reg;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic wait_adv(input int maxc, output int n);
    n = -1;
    for (int i = 1; i <= maxc; i++) begin
      @(negedge clock_reg);
      if (advance) begin
        n = i;
        break;
      end
    end
  endtask

  task automatic adv_pc(input string tag, input int exp_n, input logic [31:0] exp_pc);
    int n;
    wait_adv(20, n);
    chk({tag, "_gap"}, n, exp_n);
    @(negedge clock_reg);
    chk({tag, "_pc"}, {24'h0, PC}, exp_pc);
  endtask

  task automatic count_adv(input int k, output int c);
    c = 0;
    repeat (k) begin
      @(negedge clock_reg);
      if (advance) c++;
    end
  endtask

  task automatic press(output int c);
    int c2;
    step_n = 1'b0;
    count_adv(4, c);
    step_n = 1'b1;
    count_adv(3, c2);
    c += c2;
  endtask

  typedef struct {
    logic [2:0] f3;
    logic z, l, lu, exp;
  } br_vec_t;

  br_vec_t br_tab[8] = '{
    '{3'b000, 1'b1, 1'b0, 1'b0, 1'b1},
    '{3'b000, 1'b0, 1'b1, 1'b1, 1'b0},
    '{3'b100, 1'b0, 1'b1, 1'b0, 1'b1},
    '{3'b101, 1'b0, 1'b1, 1'b0, 1'b0},
    '{3'b110, 1'b0, 1'b0, 1'b1, 1'b1},
    '{3'b111, 1'b0, 1'b0, 1'b0, 1'b1},
    '{3'b010, 1'b1, 1'b1, 1'b1, 1'b0},
    '{3'b011, 1'b1, 1'b1, 1'b1, 1'b0}
  };

  initial begin
    int c;
    @(negedge clock_reg);
    chk("rst_pc", {24'h0, PC}, 32'h0);
    chk("rst_pcp4", {24'h0, PCp4}, 32'h4);
    chk("rst_adv", {31'h0, advance}, 32'h0);
    chk("rst_fault", {31'h0, fault}, 32'h0);
    reset = 1'b1;
    press(c);
    chk("halt10_adv", c, 0);
    mode = 2'b11;
    press(c);
    chk("halt11_adv", c, 0);
    chk("halt_pc", {24'h0, PC}, 32'h0);
    mode = 2'b01;
    count_adv(5, c);
    chk("no_queue", c, 0);
    mode = 2'b00;
    adv_pc("run1", 4, 32'h4);
    adv_pc("run2", 3, 32'h8);
    adv_pc("run3", 3, 32'hC);
    mode = 2'b01;
    step_n = 1'b0;
    count_adv(20, c);
    chk("held_adv", c, 1);
    chk("held_pc", {24'h0, PC}, 32'h10);
    step_n = 1'b1;
    count_adv(5, c);
    chk("release_adv", c, 0);
    press(c);
    chk("press2_adv", c, 1);
    chk("press2_pc", {24'h0, PC}, 32'h14);
    branch = 1'b1; funct3 = 3'b001; zero = 1'b0; imm = 8'hF8;
    #1 chk("bne_taken", {31'h0, taken}, 32'h1);
    press(c);
    chk("bne_pc", {24'h0, PC}, 32'hC);
    zero = 1'b1;
    #1 chk("bne_nt", {31'h0, taken}, 32'h0);
    press(c);
    chk("bne_nt_pc", {24'h0, PC}, 32'h10);
    foreach (br_tab[i]) begin
      funct3 = br_tab[i].f3; zero = br_tab[i].z; lt = br_tab[i].l; ltu = br_tab[i].lu;
      #1 chk($sformatf("br_f3_%0d", i), {31'h0, taken}, {31'h0, br_tab[i].exp});
    end
    jalr = 1'b1; jump = 1'b1; rs1 = 8'h21; imm = 8'h03;
    press(c);
    chk("jalr_pc", {24'h0, PC}, 32'h24);
    imm = 8'h00;
    press(c);
    chk("jalr_bit0", {24'h0, PC}, 32'h20);
    jalr = 1'b0; branch = 1'b0; imm = 8'hDC;
    press(c);
    chk("jump_pc", {24'h0, PC}, 32'hFC);
    chk("pcp4_wrap", {24'h0, PCp4}, 32'h0);
    jump = 1'b0;
    #1 chk("seq_taken", {31'h0, taken}, 32'h0);
    press(c);
    chk("wrap_pc", {24'h0, PC}, 32'h0);
    jump = 1'b1; imm = 8'h02;
    press(c);
    chk("flt_adv", c, 1);
    chk("flt_pc", {24'h0, PC}, 32'h0);
    chk("flt_set", {31'h0, fault}, 32'h1);
    mode = 2'b00;
    count_adv(12, c);
    chk("flt_run_adv", c, 0);
    chk("flt_sticky", {31'h0, fault}, 32'h1);
    jump = 1'b0;
    reset = 1'b0;
    #1 chk("flt_clr", {31'h0, fault}, 32'h0);
    @(negedge clock_reg);
    reset = 1'b1;
    adv_pc("rst1", 4, 32'h4);
    repeat (2) @(negedge clock_reg);
    reset = 1'b0;
    #1 chk("mid_rst_pc", {24'h0, PC}, 32'h0);
    chk("mid_rst_adv", {31'h0, advance}, 32'h0);
    @(negedge clock_reg);
    reset = 1'b1;
    adv_pc("rst2", 4, 32'h4);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
